id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the register file.
- Captures the two register-file read values and the decoded control fields, and presents them to EX.
- Applies a write-back bypass for the case where a write lands on the same edge as capture, and detects load-use hazards so it can insert a one-cycle bubble.
- Honours downstream stall and branch flush.

Parameters:
- DATA_W, 32, register/operand width
- ADDR_W, 5, register address width
- ALUOP_W, 4, ALU opcode width

Ports:
- clock  in  1  stage clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  ADDR_W  source 1 address; also drives register-file read_address_1 externally
- id_rs2  in  ADDR_W  source 2 address
- id_rd  in  ADDR_W  destination address
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- id_imm  in  DATA_W  sign-extended immediate
- id_alu_op  in  ALUOP_W  ALU opcode
- rf_data_1  in  DATA_W  register-file data_out_1 (sampled on negedge by the register file)
- rf_data_2  in  DATA_W  register-file data_out_2
- wb_we  in  1  write-back enable, same signal as register-file WriteEnable
- wb_addr  in  ADDR_W  write-back address
- wb_data  in  DATA_W  write-back data
- ex_stall  in  1  EX cannot accept; hold all outputs
- flush  in  1  squash the instruction being captured
- ex_valid  out  1  EX register holds a real instruction
- ex_op1  out  DATA_W  operand 1
- ex_op2  out  DATA_W  operand 2
- ex_rd  out  ADDR_W
- ex_reg_write  out  1
- ex_mem_read  out  1
- ex_imm  out  DATA_W
- ex_alu_op  out  ALUOP_W
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle

Behaviour:
- Reset: all ex_* outputs clear to 0; hazard_stall reads 0 while reset is high. Reset has priority over flush, stall and capture.
- Register 0 is an ordinary register. There is no zero special-casing anywhere, which matches the register file.
- Bypass, per operand: op1_next = wb_data if wb_we && wb_addr == id_rs1, otherwise rf_data_1. op2 uses the same rule with id_rs2 and rf_data_2.
  - Reason: the register file writes on posedge and reads on negedge, so a write on the capture edge is not yet visible in rf_data.
- Load-use hazard: hazard_stall = ex_valid && ex_mem_read && id_valid && (ex_rd == id_rs1 || ex_rd == id_rs2) && !ex_stall.
- Per-posedge priority, highest first:
  1. reset → clear.
  2. ex_stall → hold every ex_* output unchanged. hazard_stall is forced to 0 because the upstream freeze is already driven by ex_stall.
  3. flush → ex_valid <= 0; other fields are don't-care and are cleared to 0.
  4. hazard_stall → bubble: ex_valid <= 0, ex_reg_write <= 0, ex_mem_read <= 0. The ID instruction stays in ID and is re-captured next cycle, by which point the load has advanced and the hazard clears.
  5. Otherwise → capture: ex_valid <= id_valid, and all fields take the bypassed/ID values.
- When id_valid = 0, the control bits ex_reg_write and ex_mem_read are captured as 0, not as the ID values.
- A hazard can last at most one cycle for a given instruction. Two consecutive bubbles for the same instruction are a bench failure.
- flush together with hazard_stall → flush wins; the bubble is implied.
- Latency: 1 cycle from ID to EX when there is no hazard, 2 cycles when there is one.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined: adds two 32-bit outputs, perf_bubbles and perf_flushes. Each increments on the posedge where a hazard bubble or flush is applied, respectively. Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (pipeline_pkg):
  - DATA_W, ADDR_W, ALUOP_W constants
  - ALU opcode enumeration
  - id_ex_ctrl_t packed struct (reg_write, mem_read, alu_op)
- Sub-module operand_bypass: one instance per operand. It is purely combinational, takes addr, rf_data, wb_we, wb_addr and wb_data, and produces op.

Test Plan:
- Reset, then id_valid=1, rs1=3, rs2=4, rf_data=0x30/0x40, wb_we=0 → the next posedge gives ex_op1=0x30, ex_op2=0x40, ex_valid=1.
- Bypass: rs1=7, rf_data_1=0x7, wb_we=1, wb_addr=7, wb_data=0xDEADBEEF → ex_op1=0xDEADBEEF while ex_op2 is unaffected.
- Load-use: EX holds a load with rd=5; ID has rs2=5 → hazard_stall=1, the next edge gives ex_valid=0, and the edge after that captures the ID instruction with ex_valid=1.
- ex_stall held for 3 cycles with changing ID inputs → all ex_* outputs constant and hazard_stall=0 throughout.
- flush asserted while a load-use hazard is also present → ex_valid=0 after one edge, and with PERF_EN perf_flushes=1 while perf_bubbles stays 0.
- reset asserted mid-stream while ex_valid=1 → all ex_* outputs 0 on the next edge, and the first post-reset capture is correct.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: operand/address widths, ALU opcodes and the
// control bundle carried from ID into EX.
package pipeline_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  // Register 0 is an ordinary register, so a match is a plain compare.
  function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID, register-file and write-back inputs plus EX outputs.
// With ID_EX_PERF_EN defined the bubble/flush counters are carried as well.
interface id_ex_stage_if;
  import pipeline_pkg::*;

  logic               id_valid;
  logic [ADDR_W-1:0]  id_rs1;
  logic [ADDR_W-1:0]  id_rs2;
  logic [ADDR_W-1:0]  id_rd;
  logic               id_reg_write;
  logic               id_mem_read;
  logic [DATA_W-1:0]  id_imm;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [DATA_W-1:0]  rf_data_1;
  logic [DATA_W-1:0]  rf_data_2;
  logic               wb_we;
  logic [ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               ex_stall;
  logic               flush;
  logic               ex_valid;
  logic [DATA_W-1:0]  ex_op1;
  logic [DATA_W-1:0]  ex_op2;
  logic [ADDR_W-1:0]  ex_rd;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic [DATA_W-1:0]  ex_imm;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               hazard_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0]        perf_bubbles;
  logic [31:0]        perf_flushes;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           id_imm, id_alu_op, rf_data_1, rf_data_2, wb_we, wb_addr, wb_data,
           ex_stall, flush,
`ifdef ID_EX_PERF_EN
    input  perf_bubbles, perf_flushes,
`endif
    input  ex_valid, ex_op1, ex_op2, ex_rd, ex_reg_write, ex_mem_read,
           ex_imm, ex_alu_op, hazard_stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
           id_imm, id_alu_op, rf_data_1, rf_data_2, wb_we, wb_addr, wb_data,
           ex_stall, flush,
`ifdef ID_EX_PERF_EN
    output perf_bubbles, perf_flushes,
`endif
    output ex_valid, ex_op1, ex_op2, ex_rd, ex_reg_write, ex_mem_read,
           ex_imm, ex_alu_op, hazard_stall
  );

endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// Write-back bypass for one operand: a write landing on the capture edge is
// not yet visible on rf_data, so forward the write-back value instead.
module operand_bypass
  import pipeline_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op
);

  // Select write-back data on an address hit, else the register-file value.
  always_comb begin
    if (wb_we && addr_match(wb_addr, addr)) begin
      op = wb_data;
    end else begin
      op = rf_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// downstream stall and flush. Optional counters under ID_EX_PERF_EN.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic [DATA_W-1:0] op1_s;
  logic [DATA_W-1:0] op2_s;
  logic              hazard_s;
  logic              bubble_s;
  logic              flush_s;

  logic              ex_valid_d, ex_valid_q;
  logic [DATA_W-1:0] ex_op1_d,   ex_op1_q;
  logic [DATA_W-1:0] ex_op2_d,   ex_op2_q;
  logic [ADDR_W-1:0] ex_rd_d,    ex_rd_q;
  logic [DATA_W-1:0] ex_imm_d,   ex_imm_q;
  id_ex_ctrl_t       ex_ctrl_d,  ex_ctrl_q;

  operand_bypass u_bypass_1 (
    .addr    (bus.id_rs1),
    .rf_data (bus.rf_data_1),
    .wb_we   (bus.wb_we),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .op      (op1_s)
  );

  operand_bypass u_bypass_2 (
    .addr    (bus.id_rs2),
    .rf_data (bus.rf_data_2),
    .wb_we   (bus.wb_we),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data),
    .op      (op2_s)
  );

  // Load-use detection; suppressed under ex_stall, which already freezes upstream.
  always_comb begin
    if (!reset && !bus.ex_stall && ex_valid_q && ex_ctrl_q.mem_read && bus.id_valid &&
        (addr_match(ex_rd_q, bus.id_rs1) || addr_match(ex_rd_q, bus.id_rs2))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  assign flush_s  = !reset && !bus.ex_stall && bus.flush;
  assign bubble_s = hazard_s && !bus.flush;

  // Next EX register contents: reset > stall > flush > bubble > capture.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    ex_rd_d    = ex_rd_q;
    ex_imm_d   = ex_imm_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (reset || flush_s) begin
      ex_valid_d = 1'b0;
      ex_op1_d   = '0;
      ex_op2_d   = '0;
      ex_rd_d    = '0;
      ex_imm_d   = '0;
      ex_ctrl_d  = '0;
    end else if (bus.ex_stall) begin
      ex_valid_d = ex_valid_q;
    end else if (bubble_s) begin
      ex_valid_d          = 1'b0;
      ex_ctrl_d.reg_write = 1'b0;
      ex_ctrl_d.mem_read  = 1'b0;
    end else begin
      ex_valid_d          = bus.id_valid;
      ex_op1_d            = op1_s;
      ex_op2_d            = op2_s;
      ex_rd_d             = bus.id_rd;
      ex_imm_d            = bus.id_imm;
      ex_ctrl_d.alu_op    = bus.id_alu_op;
      // Squashed ID slots must not carry live control into EX.
      ex_ctrl_d.reg_write = bus.id_valid && bus.id_reg_write;
      ex_ctrl_d.mem_read  = bus.id_valid && bus.id_mem_read;
    end
  end

  // EX pipeline register.
  always_ff @(posedge clock) begin
    ex_valid_q <= ex_valid_d;
    ex_op1_q   <= ex_op1_d;
    ex_op2_q   <= ex_op2_d;
    ex_rd_q    <= ex_rd_d;
    ex_imm_q   <= ex_imm_d;
    ex_ctrl_q  <= ex_ctrl_d;
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_op1       = ex_op1_q;
  assign bus.ex_op2       = ex_op2_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_reg_write = ex_ctrl_q.reg_write;
  assign bus.ex_mem_read  = ex_ctrl_q.mem_read;
  assign bus.ex_alu_op    = ex_ctrl_q.alu_op;
  assign bus.hazard_stall = hazard_s;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles_d, perf_bubbles_q;
  logic [31:0] perf_flushes_d, perf_flushes_q;

  // Event counters; both wrap naturally at 2^32.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    if (reset) begin
      perf_bubbles_d = 32'd0;
      perf_flushes_d = 32'd0;
    end else if (flush_s) begin
      perf_flushes_d = perf_flushes_q + 32'd1;
    end else if (bubble_s) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end else begin
      perf_bubbles_d = perf_bubbles_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    perf_bubbles_q <= perf_bubbles_d;
    perf_flushes_q <= perf_flushes_d;
  end

  assign bus.perf_bubbles = perf_bubbles_q;
  assign bus.perf_flushes = perf_flushes_q;
`endif

endmodule
